muldiv_unit: RTL and testbench
==============================

# muldiv_unit

Multi-cycle RV32M multiply/divide unit in the execute stage, beside the combinational ALU. It accepts the same 5-bit ALU function code and operands as the ALU, and computes MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM and REMU over several cycles. It signals completion with a one-cycle `done` pulse, and its `result` is muxed into the writeback path. The control unit stalls the pipeline while `busy` is high.

## Interface
- `XLEN`, default 32: operand/result width; only 32 is supported.
- `clock`  in  1: rising-edge clock.
- `reset`  in  1: asynchronous, active-low reset.
- `start`  in  1: request; sampled on a rising edge only while idle.
- `flush`  in  1: synchronous abort of the operation in flight.
- `alu_function`  in  5: operation code, using the shared `ALU_MUL`…`ALU_REMU` encodings.
- `operand_a`  in  32: rs1 value, captured when `start` is accepted.
- `operand_b`  in  32: rs2 value, captured when `start` is accepted.
- `busy`  out  1: high whenever the unit is not IDLE.
- `done`  out  1: one-cycle pulse; `result` is valid in that cycle.
- `result`  out  32: registered result; held until the next `done`.

## Operation
- States:
  - IDLE → (`start`) LOAD-decision.
  - Special case → DONE.
  - Otherwise → ITER (32 cycles, counter 0..31) → DONE.
  - DONE → IDLE.
- Accept:
  - In IDLE with `start`=1, capture `alu_function`, operands and the sign flags.
  - Operands are converted to magnitudes per the function's signedness: MULHSU treats a as signed and b as unsigned; DIVU, REMU and MULHU treat both as unsigned.
- Multiply:
  - Shift-add on the 32-bit magnitudes, one bit per ITER cycle, into a 64-bit accumulator.
  - The two's-complement negation of the 64-bit product on the final edge applies iff the operand signs differ.
  - MUL returns [31:0]; MULH, MULHSU and MULHU return [63:32].
- Divide:
  - Restoring radix-2, one quotient bit per ITER cycle.
  - Quotient sign = sign(a) XOR sign(b); remainder takes the sign of a.
- Special cases (no ITER phase; DONE the next cycle):
  - Divisor 0: DIV/DIVU → 0xFFFFFFFF; REM/REMU → a.
  - a=0x80000000, b=0xFFFFFFFF, signed: DIV → 0x80000000; REM → 0.
  - Any non-M code: `result`=0.
- Boundaries:
  - `start` while `busy` (including in the DONE cycle) is ignored, not queued.
  - `flush` has priority over `start`. It forces IDLE on the next edge, with no `done` and `result` unchanged. If `start` and `flush` are both high in IDLE, the request is dropped.
  - Reset asserted mid-operation aborts immediately.

## Timing
- Reset values: state IDLE, `busy`=0, `done`=0, `result`=0, counter=0.
- `start` accepted at the end of cycle N:
  - Iterative op: ITER in cycles N+1..N+32; `done`=1 and `result` valid in cycle N+33.
  - Special case: `done` in cycle N+1.
- `busy`=1 from cycle N+1 through the `done` cycle inclusive.
- The earliest next accepted `start` is in cycle `done`+1.
- No combinational path from inputs to outputs.

## Configuration
- `FAST_MUL_EN` defined:
  - MUL* operations skip ITER. The signed 33×33 product is computed in one cycle, with `done` in N+1.
  - Divides are unchanged.
- `FAST_MUL_EN` undefined: multiplies use the 32-cycle iterative path, with `done` in N+33.
- The special-case and flush behaviour is identical in both builds.

## Structure
- Shared package (`config.sv`): `ALU_*` function codes, `ZERO`, `muldiv_state_t` enum (IDLE, ITER, DONE), iteration count constant `MULDIV_ITERS`=32.
- Sub-module `muldiv_iter_core`: the shared shift/add-subtract datapath, with a per-cycle step, `is_div` select and the 64-bit accumulator.
- The top level holds the FSM, counter, sign handling, special cases and the result register.

## Test plan
- DIV 0xFFFFFFF9 (−7) / 2, start in cycle N → `done` in N+33, `result`=0xFFFFFFFD; REM → 0xFFFFFFFF.
- MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE; MUL → 0x00000001; MULH 0x80000000 × 0x80000000 → 0x40000000.
- DIVU 5 / 0 → `done` in N+1, `result`=0xFFFFFFFF; REMU 5 / 0 → 5; DIV 0x80000000 / 0xFFFFFFFF → 0x80000000; REM → 0.
- `start` pulsed in cycles N+5 and N+33 during a divide → ignored, no extra `done`; a new `start` in N+34 is accepted.
- `flush` in cycle N+10 → IDLE in N+11, no `done`, `result` keeps its previous value; `reset` low mid-ITER → all outputs 0 immediately.
- With `FAST_MUL_EN`: MULHSU 0xFFFFFFFF × 0xFFFFFFFF → `done` in N+1, `result`=0xFFFFFFFF.

Source files
------------

// File: rtl/muldiv_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_unit_pkg
// Description : Shared ALU function codes, FSM state type and iteration
//               constants for the RV32M multiply/divide unit.
// Revision    : 1.0 - initial release
// ============================================================================
package muldiv_unit_pkg;

  localparam int          XW           = 32;
  localparam int          MULDIV_ITERS = 32;
  localparam logic [31:0] ZERO         = 32'h0000_0000;

  // Shared ALU function encodings (base ALU codes first, then RV32M)
  localparam logic [4:0] ALU_ADD    = 5'd0;
  localparam logic [4:0] ALU_SUB    = 5'd1;
  localparam logic [4:0] ALU_SLL    = 5'd2;
  localparam logic [4:0] ALU_SLT    = 5'd3;
  localparam logic [4:0] ALU_SLTU   = 5'd4;
  localparam logic [4:0] ALU_XOR    = 5'd5;
  localparam logic [4:0] ALU_SRL    = 5'd6;
  localparam logic [4:0] ALU_SRA    = 5'd7;
  localparam logic [4:0] ALU_OR     = 5'd8;
  localparam logic [4:0] ALU_AND    = 5'd9;
  localparam logic [4:0] ALU_MUL    = 5'd10;
  localparam logic [4:0] ALU_MULH   = 5'd11;
  localparam logic [4:0] ALU_MULHSU = 5'd12;
  localparam logic [4:0] ALU_MULHU  = 5'd13;
  localparam logic [4:0] ALU_DIV    = 5'd14;
  localparam logic [4:0] ALU_DIVU   = 5'd15;
  localparam logic [4:0] ALU_REM    = 5'd16;
  localparam logic [4:0] ALU_REMU   = 5'd17;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    DONE = 2'd2
  } muldiv_state_t;

  // Two's-complement negate when neg is set
  function automatic logic [31:0] neg_if(input logic [31:0] v, input logic neg);
    return neg ? (~v + 32'd1) : v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_unit_if
// Description : Request/response bundle between the execute-stage control
//               (master) and the multiply/divide unit (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface muldiv_unit_if;
  import muldiv_unit_pkg::*;

  logic          start;
  logic          flush;
  logic [4:0]    alu_function;
  logic [XW-1:0] operand_a;
  logic [XW-1:0] operand_b;
  logic          busy;
  logic          done;
  logic [XW-1:0] result;

  modport master (
    output start, flush, alu_function, operand_a, operand_b,
    input  busy, done, result
  );

  modport slave (
    input  start, flush, alu_function, operand_a, operand_b,
    output busy, done, result
  );

endinterface
`default_nettype wire

// File: rtl/muldiv_unit_iter_core.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_iter_core
// Description : Shared 64-bit accumulator datapath. One shift-add multiply
//               step or one restoring-divide step per asserted step cycle.
//               For multiply, acc ends as the 64-bit magnitude product; for
//               divide, acc[63:32] is the remainder, acc[31:0] the quotient.
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_iter_core
  import muldiv_unit_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        load,
  input  logic        step,
  input  logic        is_div,
  input  logic [31:0] load_a,
  input  logic [31:0] load_b,
  output logic [63:0] acc_next
);

  logic [63:0] acc;
  logic [31:0] opnd_b;
  logic [32:0] mul_sum;
  logic [32:0] div_shift;
  logic        div_take;
  logic [31:0] div_diff;

  // Next accumulator value for one iteration of the selected operation
  always_comb begin
    mul_sum   = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opnd_b} : 33'd0);
    // Partial remainder after the left shift can reach 33 bits; the true
    // difference is always below the divisor, so 32 bits hold it exactly.
    div_shift = acc[63:31];
    div_take  = (div_shift >= {1'b0, opnd_b});
    div_diff  = div_shift[31:0] - opnd_b;
    if (is_div) begin
      if (div_take) acc_next = {div_diff, acc[30:0], 1'b1};
      else          acc_next = {div_shift[31:0], acc[30:0], 1'b0};
    end else begin
      acc_next = {mul_sum, acc[31:1]};
    end
  end

  // Accumulator and second-operand registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      acc    <= 64'd0;
      opnd_b <= 32'd0;
    end else if (load) begin
      acc    <= {32'd0, load_a};
      opnd_b <= load_b;
    end else if (step) begin
      acc    <= acc_next;
    end
  end

endmodule
`default_nettype wire

// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_unit
// Description : Multi-cycle RV32M multiply/divide unit. FSM, iteration
//               counter, sign handling, special cases and result register.
//               Build option FAST_MUL_EN: multiplies finish in one cycle
//               using a 33x33 signed product instead of 32 iterations.
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int XLEN = 32
)(
  input  logic         clock,
  input  logic         reset,
  muldiv_unit_if.slave bus
);

  muldiv_state_t   state;
  logic [4:0]      func;
  logic            sign_a;
  logic            sign_b;
  logic [4:0]      count;
  logic            busy_r;
  logic            done_r;
  logic [XLEN-1:0] result_r;

  logic [4:0]  in_fn;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        in_a_signed;
  logic        in_b_signed;
  logic        in_sign_a;
  logic        in_sign_b;
  logic        in_is_mul;
  logic        in_is_div;
  logic [31:0] mag_a;
  logic [31:0] mag_b;
  logic        special;
  logic [31:0] special_result;
  logic        accept;
  logic        core_is_div;
  logic [63:0] acc_next;
  logic [63:0] prod;
  logic [31:0] iter_result;

  assign in_fn  = bus.alu_function;
  assign in_a   = bus.operand_a;
  assign in_b   = bus.operand_b;
  assign accept = (state == IDLE) && bus.start && !bus.flush;

`ifdef FAST_MUL_EN
  logic [63:0] fast_prod;
  // Signed 33x33 product; the low 64 bits are all any MUL* result needs
  always_comb begin
    fast_prod = $signed({{32{in_sign_a}}, in_a}) * $signed({{32{in_sign_b}}, in_b});
  end
`endif

  // Decode the incoming request: signedness, magnitudes and early-out cases
  always_comb begin
    in_is_mul   = (in_fn inside {ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU});
    in_is_div   = (in_fn inside {ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU});
    in_a_signed = (in_fn inside {ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_DIV, ALU_REM});
    in_b_signed = (in_fn inside {ALU_MUL, ALU_MULH, ALU_DIV, ALU_REM});
    in_sign_a   = in_a_signed & in_a[31];
    in_sign_b   = in_b_signed & in_b[31];
    mag_a       = neg_if(in_a, in_sign_a);
    mag_b       = neg_if(in_b, in_sign_b);

    special        = 1'b0;
    special_result = ZERO;
    if (!(in_is_mul || in_is_div)) begin
      special = 1'b1;
    end else if (in_is_div && (in_b == ZERO)) begin
      special        = 1'b1;
      special_result = (in_fn inside {ALU_DIV, ALU_DIVU}) ? 32'hFFFF_FFFF : in_a;
    end else if ((in_fn inside {ALU_DIV, ALU_REM}) &&
                 (in_a == 32'h8000_0000) && (in_b == 32'hFFFF_FFFF)) begin
      special        = 1'b1;
      special_result = (in_fn == ALU_DIV) ? 32'h8000_0000 : ZERO;
    end
`ifdef FAST_MUL_EN
    else if (in_is_mul) begin
      special        = 1'b1;
      special_result = (in_fn == ALU_MUL) ? fast_prod[31:0] : fast_prod[63:32];
    end
`endif
  end

  assign core_is_div = (func inside {ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU});

  muldiv_iter_core u_core (
    .clock    (clock),
    .reset    (reset),
    .load     (accept),
    .step     (state == ITER),
    .is_div   (core_is_div),
    .load_a   (mag_a),
    .load_b   (mag_b),
    .acc_next (acc_next)
  );

  // Apply signs to the final iteration and pick the requested word
  always_comb begin
    prod = (sign_a ^ sign_b) ? (~acc_next + 64'd1) : acc_next;
    unique case (func)
      ALU_MUL:                        iter_result = prod[31:0];
      ALU_MULH, ALU_MULHSU, ALU_MULHU: iter_result = prod[63:32];
      ALU_DIV, ALU_DIVU:              iter_result = neg_if(acc_next[31:0], sign_a ^ sign_b);
      ALU_REM, ALU_REMU:              iter_result = neg_if(acc_next[63:32], sign_a);
      default:                        iter_result = ZERO;
    endcase
  end

  // Control FSM with registered busy/done/result
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      func     <= ALU_ADD;
      sign_a   <= 1'b0;
      sign_b   <= 1'b0;
      count    <= 5'd0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      result_r <= '0;
    end else begin
      done_r <= 1'b0;
      if (bus.flush) begin
        state  <= IDLE;
        busy_r <= 1'b0;
        count  <= 5'd0;
      end else begin
        case (state)
          IDLE: begin
            if (bus.start) begin
              func   <= in_fn;
              sign_a <= in_sign_a;
              sign_b <= in_sign_b;
              busy_r <= 1'b1;
              count  <= 5'd0;
              if (special) begin
                result_r <= special_result;
                done_r   <= 1'b1;
                state    <= DONE;
              end else begin
                state    <= ITER;
              end
            end
          end
          ITER: begin
            if (count == 5'(MULDIV_ITERS - 1)) begin
              result_r <= iter_result;
              done_r   <= 1'b1;
              count    <= 5'd0;
              state    <= DONE;
            end else begin
              count <= count + 5'd1;
            end
          end
          DONE: begin
            busy_r <= 1'b0;
            state  <= IDLE;
          end
          default: begin
            busy_r <= 1'b0;
            state  <= IDLE;
          end
        endcase
      end
    end
  end

  assign bus.busy   = busy_r;
  assign bus.done   = done_r;
  assign bus.result = result_r;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_muldiv_unit
// Description : Self-checking bench for muldiv_unit. Directed cases plus
//               random RV32M operations against an arithmetic reference.
//               Honours FAST_MUL_EN for expected multiply latency.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_muldiv_unit;
  import muldiv_unit_pkg::*;

  logic clock;
  logic reset;
  int   checks;
  int   errors;

  muldiv_unit_if bus ();

  muldiv_unit #(.XLEN(32)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // RV32M semantics written with plain 64-bit arithmetic
  function automatic logic [31:0] ref_result(input logic [4:0] f, input logic [31:0] a,
                                              input logic [31:0] b);
    logic signed [63:0] sa, sb, ua, ub;
    logic [63:0] p;
    sa = $signed({{32{a[31]}}, a});
    sb = $signed({{32{b[31]}}, b});
    ua = $signed({32'd0, a});
    ub = $signed({32'd0, b});
    p  = 64'd0;
    case (f)
      ALU_MUL:    begin p = sa * sb; return p[31:0];  end
      ALU_MULH:   begin p = sa * sb; return p[63:32]; end
      ALU_MULHSU: begin p = sa * ub; return p[63:32]; end
      ALU_MULHU:  begin p = ua * ub; return p[63:32]; end
      ALU_DIV: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        p = sa / sb; return p[31:0];
      end
      ALU_DIVU: begin
        if (b == 0) return 32'hFFFF_FFFF;
        p = ua / ub; return p[31:0];
      end
      ALU_REM: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        p = sa % sb; return p[31:0];
      end
      ALU_REMU: begin
        if (b == 0) return a;
        p = ua % ub; return p[31:0];
      end
      default: return 32'd0;
    endcase
  endfunction

  // Cycles from acceptance to the done cycle
  function automatic int ref_latency(input logic [4:0] f, input logic [31:0] a,
                                     input logic [31:0] b);
    if (f < ALU_MUL || f > ALU_REMU) return 1;
    if (f >= ALU_DIV) begin
      if (b == 0) return 1;
      if ((f == ALU_DIV || f == ALU_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
      return 33;
    end
`ifdef FAST_MUL_EN
    return 1;
`else
    return 33;
`endif
  endfunction

  task automatic run_op(input string tag, input logic [4:0] f, input logic [31:0] a,
                        input logic [31:0] b);
    int cyc;
    logic [31:0] exp_r;
    exp_r = ref_result(f, a, b);
    @(negedge clock);
    bus.start = 1'b1; bus.alu_function = f; bus.operand_a = a; bus.operand_b = b;
    @(posedge clock); #1;
    // Inputs change after acceptance; the unit must work from captured copies
    bus.start = 1'b0; bus.alu_function = ALU_ADD;
    bus.operand_a = $urandom; bus.operand_b = $urandom;
    check($sformatf("%s_busy", tag), {31'd0, bus.busy}, 32'd1);
    cyc = 1;
    while (bus.done !== 1'b1 && cyc < 60) begin
      @(posedge clock); #1;
      cyc++;
    end
    check($sformatf("%s_latency", tag), cyc, ref_latency(f, a, b));
    check($sformatf("%s_result", tag), bus.result, exp_r);
    check($sformatf("%s_busy_at_done", tag), {31'd0, bus.busy}, 32'd1);
    @(posedge clock); #1;
    check($sformatf("%s_idle_after", tag), {30'd0, bus.busy, bus.done}, 32'd0);
  endtask

  initial begin
    int ndone;
    int done_at;
    logic [31:0] prev;
    logic [4:0] rf;
    logic [31:0] ra, rb;

    checks = 0; errors = 0;
    reset = 1'b0;
    bus.start = 1'b0; bus.flush = 1'b0; bus.alu_function = ALU_ADD;
    bus.operand_a = 32'd0; bus.operand_b = 32'd0;
    repeat (2) @(posedge clock);
    #1;
    check("reset_outputs", {bus.busy, bus.done, bus.result[29:0]}, 32'd0);
    check("reset_result", bus.result, 32'd0);
    @(negedge clock); reset = 1'b1;
    repeat (2) @(posedge clock);

    // Directed arithmetic cases
    run_op("div_m7_2",     ALU_DIV,    32'hFFFF_FFF9, 32'd2);
    run_op("rem_m7_2",     ALU_REM,    32'hFFFF_FFF9, 32'd2);
    run_op("mulhu_ff_ff",  ALU_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op("mul_ff_ff",    ALU_MUL,    32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op("mulh_min_min", ALU_MULH,   32'h8000_0000, 32'h8000_0000);
    run_op("mulhsu_ff_ff", ALU_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op("divu_5_0",     ALU_DIVU,   32'd5, 32'd0);
    run_op("remu_5_0",     ALU_REMU,   32'd5, 32'd0);
    run_op("div_ovf",      ALU_DIV,    32'h8000_0000, 32'hFFFF_FFFF);
    run_op("rem_ovf",      ALU_REM,    32'h8000_0000, 32'hFFFF_FFFF);
    run_op("non_m_code",   ALU_XOR,    32'h1234_5678, 32'h0F0F_0F0F);
    run_op("divu_big",     ALU_DIVU,   32'hFFFF_FFFF, 32'd3);

    // Stray starts during a divide (cycles N+5 and the done cycle N+33)
    @(negedge clock);
    bus.start = 1'b1; bus.alu_function = ALU_DIV; bus.operand_a = 32'd100; bus.operand_b = 32'd7;
    @(posedge clock); #1;
    bus.start = 1'b0;
    ndone = 0; done_at = 0;
    for (int k = 1; k <= 33; k++) begin
      if (bus.done === 1'b1) begin ndone++; done_at = k; end
      @(negedge clock);
      bus.start = (k == 5 || k == 33);
      bus.alu_function = ALU_ADD;
      @(posedge clock); #1;
    end
    bus.start = 1'b0;
    check("stray_start_done_count", ndone, 32'd1);
    check("stray_start_done_cycle", done_at, 32'd33);
    check("stray_start_no_extra_done", {31'd0, bus.done}, 32'd0);
    check("stray_start_result", bus.result, 32'd14);
    // New request in cycle N+34 is accepted
    run_op("after_stray_divu0", ALU_DIVU, 32'd9, 32'd0);

    // Flush mid-iteration
    run_op("pre_flush_mulhu", ALU_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    prev = 32'hFFFF_FFFE;
    @(negedge clock);
    bus.start = 1'b1; bus.alu_function = ALU_DIV; bus.operand_a = 32'd1000; bus.operand_b = 32'd3;
    @(posedge clock); #1;
    bus.start = 1'b0;
    repeat (9) @(posedge clock);
    #1;
    bus.flush = 1'b1;
    @(posedge clock); #1;
    bus.flush = 1'b0;
    check("flush_busy_done", {30'd0, bus.busy, bus.done}, 32'd0);
    check("flush_result_kept", bus.result, prev);
    ndone = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clock); #1;
      if (bus.done === 1'b1) ndone++;
    end
    check("flush_no_done", ndone, 32'd0);

    // Flush together with start in IDLE drops the request
    @(negedge clock);
    bus.start = 1'b1; bus.flush = 1'b1; bus.alu_function = ALU_DIVU;
    bus.operand_a = 32'd7; bus.operand_b = 32'd0;
    @(posedge clock); #1;
    bus.start = 1'b0; bus.flush = 1'b0;
    check("flush_start_busy", {31'd0, bus.busy}, 32'd0);
    @(posedge clock); #1;
    check("flush_start_no_done", {31'd0, bus.done}, 32'd0);
    check("flush_start_result", bus.result, prev);

    // Asynchronous reset mid-iteration
    @(negedge clock);
    bus.start = 1'b1; bus.alu_function = ALU_REMU; bus.operand_a = 32'd77; bus.operand_b = 32'd5;
    @(posedge clock); #1;
    bus.start = 1'b0;
    repeat (5) @(posedge clock);
    #2;
    check("pre_reset_busy", {31'd0, bus.busy}, 32'd1);
    reset = 1'b0;
    #1;
    check("async_reset_busy_done", {30'd0, bus.busy, bus.done}, 32'd0);
    check("async_reset_result", bus.result, 32'd0);
    @(negedge clock); reset = 1'b1;
    run_op("after_reset_rem", ALU_REM, 32'hFFFF_FF9C, 32'd7);

    // Randomized operations against the reference model
    for (int i = 0; i < 40; i++) begin
      rf = (($urandom_range(0, 7) == 0) ? 5'($urandom_range(0, 9)) : 5'(ALU_MUL + $urandom_range(0, 7)));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: rb = 32'($urandom_range(1, 15));
        2: ra = 32'h8000_0000;
        3: rb = 32'hFFFF_FFFF;
        default: ;
      endcase
      run_op($sformatf("rand%0d", i), rf, ra, rb);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
